// File: rtl/run_ctrl_pkg.sv
// Shared types for the multi-core run-control sequencer.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    VGA     = 3'd2,
    HALT    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam int STOP_ALL = 0;
  localparam int STOP_ANY = 1;

endpackage

// File: rtl/clk_en_divider.sv
// Free-running clock-enable divider: one-cycle tick every DIV enabled cycles.
// The tick is decoded from the registered count, so it needs no extra pipeline stage.
module clk_en_divider #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority so the next phase always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable & (cnt_q == LAST);

endmodule

// File: rtl/multi_core_run_ctrl.sv
// Run-control sequencer: gates per-core clock enables during RUN, then a divided
// VGA phase, then HALT; a cycle watchdog traps runaway runs in TIMEOUT.
module multi_core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                N_CORES    = 2,
  parameter int                STOP_MODE  = 0,
  parameter int                VGA_DIV    = 4,
  parameter int                CNT_W      = 24,
  parameter logic [CNT_W-1:0]  MAX_CYCLES = {CNT_W{1'b1}}
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_CORES-1:0] core_done,
  input  logic               vga_done,
  output logic [N_CORES-1:0] core_en,
  output logic               vga_tick,
  output logic [CNT_W-1:0]   run_cycles,
  output logic [N_CORES-1:0] done_mask,
  output logic [2:0]         state_o,
  output logic               halted,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] LIMIT = MAX_CYCLES - CNT_W'(1);

  state_t             state_q, state_d;
  logic [N_CORES-1:0] mask_q, mask_d, mask_run;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               stop, at_limit, freeze, vga_clear;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cyc_d    = cyc_q;
    mask_run = mask_q | core_done;
    stop     = (STOP_MODE == STOP_ANY) ? (|mask_run) : (&mask_run);
    at_limit = (cyc_q == LIMIT);
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          mask_d  = '0;
          cyc_d   = '0;
        end
      end
      RUN: begin
        mask_d = mask_run;
        if (!(&cyc_q)) cyc_d = cyc_q + CNT_W'(1);
        // A stop seen on the watchdog's last cycle still counts as a clean stop.
        if (stop) begin
          state_d = VGA;
        end else if (at_limit) begin
          state_d = TIMEOUT;
        end
      end
      VGA: begin
        if (vga_done) state_d = HALT;
      end
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cyc_q   <= cyc_d;
    end
  end

  assign freeze    = (STOP_MODE == STOP_ANY) && (|mask_q);
  assign core_en   = ((state_q == RUN) && !freeze) ? ~mask_q : '0;
  assign vga_clear = (state_q != VGA) | vga_done;

  clk_en_divider #(
    .DIV(VGA_DIV)
  ) u_vga_div (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (state_q == VGA),
    .clear  (vga_clear),
    .tick   (vga_tick)
  );

  assign run_cycles = cyc_q;
  assign done_mask  = mask_q;
  assign state_o    = state_q;
  assign halted     = (state_q == HALT);
  assign timeout    = (state_q == TIMEOUT);

endmodule

// File: tb/tb_multi_core_run_ctrl.sv
// Scoreboard bench: two instances (stop-on-all, stop-on-any) share random stimulus
// and are checked against a phase-level reference model every cycle.
module tb_multi_core_run_ctrl;

  localparam int NC   = 2;
  localparam int DIV  = 4;
  localparam int CW   = 24;
  localparam int MAXC = 16;

  typedef struct packed {
    logic [NC-1:0] en;
    logic          tick;
    logic [CW-1:0] cyc;
    logic [NC-1:0] mask;
    logic [2:0]    st;
    logic          halted;
    logic          tmo;
  } obs_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          vga_done = 1'b0;
  logic [NC-1:0] core_done = '0;
  logic [NC-1:0] rnd_done;

  logic [NC-1:0] en0, en1, mask0, mask1;
  logic          tick0, tick1, h0, h1, to0, to1;
  logic [CW-1:0] cyc0, cyc1;
  logic [2:0]    st0, st1;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0..4 per instance, instance 0 stops on all, 1 on any.
  int            ph [2];
  logic [NC-1:0] mm [2];
  int            cyc [2];
  int            vc [2];

  obs_t exp0_q[$];
  obs_t exp1_q[$];

  always #5 clock = ~clock;

  multi_core_run_ctrl #(
    .N_CORES(NC), .STOP_MODE(0), .VGA_DIV(DIV), .CNT_W(CW), .MAX_CYCLES(24'd16)
  ) dut_all (
    .clock(clock), .reset_n(reset_n), .start(start), .core_done(core_done),
    .vga_done(vga_done), .core_en(en0), .vga_tick(tick0), .run_cycles(cyc0),
    .done_mask(mask0), .state_o(st0), .halted(h0), .timeout(to0)
  );

  multi_core_run_ctrl #(
    .N_CORES(NC), .STOP_MODE(1), .VGA_DIV(DIV), .CNT_W(CW), .MAX_CYCLES(24'd16)
  ) dut_any (
    .clock(clock), .reset_n(reset_n), .start(start), .core_done(core_done),
    .vga_done(vga_done), .core_en(en1), .vga_tick(tick1), .run_cycles(cyc1),
    .done_mask(mask1), .state_o(st1), .halted(h1), .timeout(to1)
  );

  function automatic string fmt(obs_t o);
    return $sformatf("en=%b tick=%b cyc=%0d mask=%b st=%0d halt=%b tmo=%b",
                     o.en, o.tick, o.cyc, o.mask, o.st, o.halted, o.tmo);
  endfunction

  function automatic void cmp(string name, obs_t act, obs_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(req));
    end
  endfunction

  function automatic obs_t act_of(int i);
    obs_t o;
    if (i == 0) begin
      o.en = en0; o.tick = tick0; o.cyc = cyc0; o.mask = mask0;
      o.st = st0; o.halted = h0; o.tmo = to0;
    end else begin
      o.en = en1; o.tick = tick1; o.cyc = cyc1; o.mask = mask1;
      o.st = st1; o.halted = h1; o.tmo = to1;
    end
    return o;
  endfunction

  function automatic obs_t expect_of(int i);
    obs_t o;
    o        = '0;
    o.st     = 3'(ph[i]);
    o.halted = (ph[i] == 3);
    o.tmo    = (ph[i] == 4);
    o.mask   = mm[i];
    o.cyc    = CW'(cyc[i]);
    if (ph[i] == 1 && !(i == 1 && mm[i] != 0)) o.en = ~mm[i];
    o.tick   = (ph[i] == 2) && (vc[i] % DIV == DIV - 1);
    return o;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; mm[i] = '0; cyc[i] = 0; vc[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      case (ph[i])
        0, 3: begin
          if (start) begin ph[i] = 1; mm[i] = '0; cyc[i] = 0; end
        end
        1: begin
          logic [NC-1:0] nm;
          bit            stp;
          nm  = mm[i] | core_done;
          stp = (i == 1) ? (nm != 0) : (nm == {NC{1'b1}});
          if (stp) begin ph[i] = 2; vc[i] = 0; end
          else if (cyc[i] == MAXC - 1) ph[i] = 4;
          mm[i] = nm;
          if (cyc[i] < (1 << CW) - 1) cyc[i]++;
        end
        2: begin
          if (vga_done) ph[i] = 3; else vc[i]++;
        end
        default: ;
      endcase
    end
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    exp0_q.push_back(expect_of(0));
    exp1_q.push_back(expect_of(1));
  endtask

  task automatic drive(input bit s, input logic [NC-1:0] d, input bit v);
    start = s; core_done = d; vga_done = v;
    step();
  endtask

  // Reset lands between edges; outputs must drop before any clock arrives.
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset_n = 1'b0; start = 1'b0; core_done = '0; vga_done = 1'b0;
    model_reset();
    #1;
    cmp("async_reset_all", act_of(0), expect_of(0));
    cmp("async_reset_any", act_of(1), expect_of(1));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp0_q.push_back(expect_of(0));
    exp1_q.push_back(expect_of(1));
  endtask

  always @(negedge clock) begin
    if (exp0_q.size() > 0) cmp("cycle_all", act_of(0), exp0_q.pop_front());
    if (exp1_q.size() > 0) cmp("cycle_any", act_of(1), exp1_q.pop_front());
  end

  initial begin
    model_reset();
    do_reset();

    // Staggered core completion, VGA phase with ticks, HALT, restart.
    drive(1'b1, '0, 1'b0);
    for (int k = 0; k < 12; k++)
      drive(1'b0, (k == 5) ? 2'b01 : ((k == 9) ? 2'b10 : 2'b00), 1'b0);
    for (int v = 0; v < 14; v++) drive(1'b0, '0, v == 12);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 2'b01, 1'b0);
    drive(1'b0, '0, 1'b0);

    // Watchdog expiry; start must not leave TIMEOUT.
    do_reset();
    drive(1'b1, '0, 1'b0);
    repeat (18) drive(1'b0, '0, 1'b0);
    repeat (3) drive(1'b1, '0, 1'b0);
    do_reset();

    // All cores finish on the watchdog's final cycle.
    drive(1'b1, '0, 1'b0);
    repeat (15) drive(1'b0, '0, 1'b0);
    drive(1'b0, 2'b11, 1'b0);
    repeat (6) drive(1'b0, '0, 1'b0);

    // Reset while in VGA, just after a tick.
    do_reset();
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 2'b11, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      rnd_done = ($urandom_range(0, 9) == 0) ? NC'($urandom) : '0;
      drive($urandom_range(0, 7) == 0, rnd_done, $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
